// File: rtl/burst_ram_pkg.sv
// burst_ram_pkg: shared types and constants for the burst RAM responder.
// Holds the FSM state encoding, the br_cmd encoding and the counter sizing helper.
package burst_ram_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE      = 2'd1,
      READ_WAIT  = 2'd2,
      READ_BURST = 2'd3
   } burst_ram_state_t;

   localparam logic CMD_READ  = 1'b0;
   localparam logic CMD_WRITE = 1'b1;

   // One counter serves both the latency wait and the burst beats, so it
   // must hold values up to max(READ_LATENCY, BURST_LENGTH) - 1.
   function automatic int cnt_width(input int read_latency, input int burst_length);
      return (read_latency > burst_length) ? $clog2(read_latency) : $clog2(burst_length);
   endfunction

endpackage

// File: rtl/burst_ram_mem.sv
// burst_ram_mem: single-port 64-bit block RAM with per-byte write enables
// and a registered (1-cycle) read port.
module burst_ram_mem
   import burst_ram_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter     INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic              re,
   input  logic [7:0]        be,
   input  logic [ADDR_W-1:0] addr,
   input  logic [63:0]       wdata,
   output logic [63:0]       rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [63:0] mem_array [DEPTH];

   // Byte-granular write; bytes with a cleared enable keep their old value.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 8; i++) begin
            if (be[i]) begin
               mem_array[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
   end

   // Registered read; the output register holds its value between reads.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem_array[addr];
      end
   end

endmodule

// File: rtl/burst_ram.sv
// burst_ram: memory end of the br_ interface. Serves fixed-length read and
// write bursts from on-chip block RAM with a configurable read latency.
// Optional feature: define BURST_RAM_DATA_MASK_EN to honour br_data_mask
// per byte; otherwise all 8 bytes are written on every write beat.
module burst_ram
   import burst_ram_pkg::*;
#(
   parameter int DEPTH_BITWIDTH = 10,
   parameter int BURST_LENGTH   = 4,
   parameter int READ_LATENCY   = 4,
   parameter     INIT_FILE      = ""
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      br_cmd,
   input  logic                      br_cmd_en,
   input  logic [DEPTH_BITWIDTH-1:0] br_addr,
   input  logic [63:0]               br_wr_data,
   input  logic [7:0]                br_data_mask,
   output logic [63:0]               br_rd_data,
   output logic                      br_rd_data_valid,
   output logic                      busy,
   output logic                      cmd_dropped
);

   localparam int CNT_W = cnt_width(READ_LATENCY, BURST_LENGTH);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LENGTH - 1);

   burst_ram_state_t          state_reg, state_next;
   logic [CNT_W-1:0]          cnt_reg, cnt_next;
   logic [DEPTH_BITWIDTH-1:0] addr_reg, addr_next;
   logic                      busy_reg, valid_reg, dropped_reg;
   logic                      mem_we, mem_re;
   logic [DEPTH_BITWIDTH-1:0] mem_addr;
   logic [7:0]                mem_be;

`ifdef BURST_RAM_DATA_MASK_EN
   assign mem_be = ~br_data_mask;
`else
   logic unused_mask;
   assign unused_mask = ^br_data_mask;
   assign mem_be      = 8'hFF;
`endif

   // Next-state, counter and address generation; memory strobes decoded here.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      addr_next  = addr_reg;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_addr   = addr_reg;
      case (state_reg)
         IDLE: begin
            // Word 0 of a write lands in the acceptance cycle itself.
            mem_addr = br_addr;
            if (br_cmd_en) begin
               cnt_next = CNT_W'(1);
               if (br_cmd == CMD_WRITE) begin
                  mem_we     = 1'b1;
                  addr_next  = br_addr + 1'b1;
                  state_next = WRITE;
               end else begin
                  addr_next  = br_addr;
                  state_next = READ_WAIT;
               end
            end
         end
         WRITE: begin
            mem_we    = 1'b1;
            addr_next = addr_reg + 1'b1;
            cnt_next  = cnt_reg + 1'b1;
            if (cnt_reg == BURST_LAST) begin
               state_next = IDLE;
            end
         end
         READ_WAIT: begin
            // The first address goes out one cycle early to cover the RAM read register.
            if (cnt_reg == WAIT_LAST) begin
               mem_re     = 1'b1;
               addr_next  = addr_reg + 1'b1;
               cnt_next   = '0;
               state_next = READ_BURST;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         READ_BURST: begin
            // cnt_reg is the index of the beat currently on br_rd_data.
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == BURST_LAST) begin
               state_next = IDLE;
            end else begin
               mem_re    = 1'b1;
               addr_next = addr_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         addr_reg    <= '0;
         busy_reg    <= 1'b0;
         valid_reg   <= 1'b0;
         dropped_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         addr_reg  <= addr_next;
         busy_reg  <= (state_next != IDLE);
         valid_reg <= mem_re;
         if (br_cmd_en && busy_reg) begin
            dropped_reg <= 1'b1;
         end
      end
   end

   // Strobes are gated by reset so an aborted burst touches nothing at the reset edge.
   burst_ram_mem #(
      .ADDR_W    (DEPTH_BITWIDTH),
      .INIT_FILE (INIT_FILE)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we & rst_n),
      .re    (mem_re & rst_n),
      .be    (mem_be),
      .addr  (mem_addr),
      .wdata (br_wr_data),
      .rdata (br_rd_data)
   );

   assign br_rd_data_valid = valid_reg;
   assign busy             = busy_reg;
   assign cmd_dropped      = dropped_reg;

endmodule
